mem_copy_ctrl: RTL

- Initiator (master) for the single-port simulation RAM interface (AAddr/AMosi/AMiso/AWrEn/ARdEn, one-cycle read latency).
- Executes block commands against that RAM: copy N words from a source to a destination region, or fill N words with a pattern.
- Used by test benches and boot/init logic to preload, move and clear memory images without a CPU.

---
 rtl/mem_copy_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_copy_ctrl.sv
// Block copy / fill initiator for the single-port simulation RAM.
// Copies ascend word by word (RD then WR); fills write one word per cycle.
module mem_copy_ctrl #(
  parameter int CAddrLen = 13,
  parameter int CDataLen = 128
) (
  input  logic                AClkH,
  input  logic                AResetH,
  input  logic                AClkHEn,
  input  logic                ACmdStart,
  input  logic                ACmdMode,
  input  logic [CAddrLen-1:0] ACmdSrc,
  input  logic [CAddrLen-1:0] ACmdDst,
  input  logic [CAddrLen:0]   ACmdLen,
  input  logic [CDataLen-1:0] ACmdPattern,
  input  logic                AAbort,
  output logic                ABusy,
  output logic                ADone,
  output logic                AAborted,
  output logic [CAddrLen:0]   AWordsDone,
  output logic [CAddrLen-1:0] AMemAddr,
  output logic [CDataLen-1:0] AMemMosi,
  input  logic [CDataLen-1:0] AMemMiso,
  output logic                AMemWrEn,
  output logic                AMemRdEn
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FILL,
    S_DONE
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CAddrLen-1:0] src_q;
  logic [CAddrLen-1:0] dst_q;
  logic [CAddrLen:0]   len_q;
  logic [CAddrLen:0]   wd_q;
  logic [CAddrLen:0]   wd_inc;
  logic [CDataLen-1:0] pat_q;
  logic                abort_q;
  logic                stop;

  assign wd_inc     = wd_q + {{CAddrLen{1'b0}}, 1'b1};
  assign stop       = (wd_inc == len_q) | abort_q | AAbort;
  assign AWordsDone = wd_q;

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      state_q <= S_IDLE;
    end else if (AClkHEn) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ABusy    = 1'b1;
    ADone    = 1'b0;
    AAborted = 1'b0;
    AMemAddr = '0;
    AMemMosi = '0;
    AMemWrEn = 1'b0;
    AMemRdEn = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ABusy = 1'b0;
        if (ACmdStart) begin
          if (ACmdLen == '0) state_d = S_DONE;
          else if (ACmdMode) state_d = S_FILL;
          else               state_d = S_RD;
        end
      end
      S_RD: begin
        AMemRdEn = 1'b1;
        AMemAddr = src_q + wd_q[CAddrLen-1:0];
        state_d  = S_WR;
      end
      S_WR: begin
        AMemWrEn = 1'b1;
        AMemAddr = dst_q + wd_q[CAddrLen-1:0];
        AMemMosi = AMemMiso;
        state_d  = stop ? S_DONE : S_RD;
      end
      S_FILL: begin
        AMemWrEn = 1'b1;
        AMemAddr = dst_q + wd_q[CAddrLen-1:0];
        AMemMosi = pat_q;
        state_d  = stop ? S_DONE : S_FILL;
      end
      S_DONE: begin
        ADone    = 1'b1;
        AAborted = abort_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command registers; the copy/fill mode lives in the state itself.
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      wd_q    <= '0;
      abort_q <= 1'b0;
    end else if (AClkHEn) begin
      unique case (state_q)
        S_IDLE: begin
          if (ACmdStart) begin
            src_q   <= ACmdSrc;
            dst_q   <= ACmdDst;
            len_q   <= ACmdLen;
            pat_q   <= ACmdPattern;
            wd_q    <= '0;
            abort_q <= 1'b0;
          end
        end
        S_RD: begin
          if (AAbort) abort_q <= 1'b1;
        end
        S_WR, S_FILL: begin
          wd_q <= wd_inc;
          if (AAbort) abort_q <= 1'b1;
        end
        S_DONE: abort_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
